// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: forwarding, load-use stall, flush, memory-wait freeze.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_controller #(
   parameter int WAIT_TIMEOUT = 16,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1_D,
   input  logic [4:0]       rs2_D,
   input  logic [4:0]       rs1_E,
   input  logic [4:0]       rs2_E,
   input  logic [4:0]       rd_E,
   input  logic [4:0]       rd_M,
   input  logic [4:0]       rd_W,
   input  logic             regwrite_M,
   input  logic             regwrite_W,
   input  logic [1:0]       resultsrc_E,
   input  logic             pcsrc_E,
   input  logic             memaccess_M,
   input  logic             dmem_ready,
   output logic [1:0]       forwardA_E,
   output logic [1:0]       forwardB_E,
   output logic             stall_F,
   output logic             stall_D,
   output logic             stall_E,
   output logic             stall_M,
   output logic             stall_W,
   output logic             flush_D,
   output logic             flush_E,
   output logic             dmem_timeout,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] perf_stall,
   output logic [CNT_W-1:0] perf_flush,
   output logic [CNT_W-1:0] perf_memwait
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HUNG     = 2'd2
   } state_e;

   localparam int            WC_W        = $clog2(WAIT_TIMEOUT + 1);
   localparam logic [WC_W-1:0] WC_ONE    = WC_W'(1);
   localparam logic [WC_W-1:0] WC_LIMIT  = WC_W'(WAIT_TIMEOUT);

   state_e          state_q;
   logic [WC_W-1:0] wait_cnt_q;
   logic            timeout_q;

   logic       lw_stall;
   logic       mem_hold;
   logic       freeze;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;

   // The Memory stage holds the younger result, so it wins over Writeback.
   assign fwd_a = (regwrite_M && rd_M != 5'd0 && rd_M == rs1_E) ? 2'b10 :
                  (regwrite_W && rd_W != 5'd0 && rd_W == rs1_E) ? 2'b01 : 2'b00;
   assign fwd_b = (regwrite_M && rd_M != 5'd0 && rd_M == rs2_E) ? 2'b10 :
                  (regwrite_W && rd_W != 5'd0 && rd_W == rs2_E) ? 2'b01 : 2'b00;

   assign lw_stall = (resultsrc_E == 2'b01) && (rd_E != 5'd0) &&
                     ((rd_E == rs1_D) || (rd_E == rs2_D));
   assign mem_hold = memaccess_M && !dmem_ready;
   assign freeze   = mem_hold || (state_q == HUNG);

   // Freeze suppresses every flush so the Execute instruction and its pcsrc_E survive the wait.
   assign forwardA_E = rst ? 2'b00 : fwd_a;
   assign forwardB_E = rst ? 2'b00 : fwd_b;
   assign stall_F    = !rst && (lw_stall || freeze);
   assign stall_D    = !rst && (lw_stall || freeze);
   assign stall_E    = !rst && freeze;
   assign stall_M    = !rst && freeze;
   assign stall_W    = !rst && freeze;
   assign flush_D    = rst || (pcsrc_E && !freeze);
   assign flush_E    = rst || ((lw_stall || pcsrc_E) && !freeze);

   assign state_o      = state_q;
   assign dmem_timeout = timeout_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (mem_hold) begin
                  state_q    <= MEM_WAIT;
                  wait_cnt_q <= WC_ONE;
               end else begin
                  wait_cnt_q <= '0;
               end
            end
            MEM_WAIT: begin
               // A dropped memaccess_M ends the wait just like a ready handshake.
               if (!mem_hold) begin
                  state_q    <= RUN;
                  wait_cnt_q <= '0;
               end else if (wait_cnt_q == WC_LIMIT) begin
                  state_q   <= HUNG;
                  timeout_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + WC_ONE;
               end
            end
            HUNG:    state_q <= HUNG;
            default: state_q <= RUN;
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [CNT_W-1:0] PERF_ONE = CNT_W'(1);

   logic [CNT_W-1:0] perf_stall_q;
   logic [CNT_W-1:0] perf_flush_q;
   logic [CNT_W-1:0] perf_memwait_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_q   <= '0;
         perf_flush_q   <= '0;
         perf_memwait_q <= '0;
      end else begin
         if (stall_F)            perf_stall_q   <= perf_stall_q + PERF_ONE;
         if (flush_D || flush_E) perf_flush_q   <= perf_flush_q + PERF_ONE;
         if (mem_hold)           perf_memwait_q <= perf_memwait_q + PERF_ONE;
      end
   end

   assign perf_stall   = perf_stall_q;
   assign perf_flush   = perf_flush_q;
   assign perf_memwait = perf_memwait_q;
`else
   assign perf_stall   = '0;
   assign perf_flush   = '0;
   assign perf_memwait = '0;
`endif

endmodule
